// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage 16-bit pipeline.
// Drives freeze/flush controls for PC, IF/ID, ID/EX and EX/MEM, selects
// ALU operand forwarding paths, and tracks data-memory wait states with a
// timeout watchdog plus a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic [3:0]       ID_Src1,
    input  logic [3:0]       ID_Src2,
    input  logic             ID_Src2Valid,
    input  logic [3:0]       EX_Src1,
    input  logic [3:0]       EX_Src2,
    input  logic [3:0]       EX_DstReg,
    input  logic             EX_WBEnable,
    input  logic             EX_MemRead,
    input  logic             EX_BrTaken,
    input  logic [3:0]       MEM_DstReg,
    input  logic             MEM_WBEnable,
    input  logic             MEM_Req,
    input  logic             MEM_Ready,
    input  logic [3:0]       WB_DstReg,
    input  logic             WB_WBEnable,
    output logic             PC_Freeze,
    output logic             IFID_Freeze,
    output logic             IFID_Flush,
    output logic             IDEX_Freeze,
    output logic             IDEX_Flush,
    output logic             EXMEM_Freeze,
    output logic [1:0]       Fwd_Sel1,
    output logic [1:0]       Fwd_Sel2,
    output logic [1:0]       State,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic mem_stall;
    logic load_use;

    // Operand source select; the younger EX/MEM result beats the WB value,
    // and register 0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic [3:0] mem_dst,
        input logic       mem_wb,
        input logic [3:0] wb_dst,
        input logic       wb_wb
    );
        if (mem_wb && (mem_dst != 4'd0) && (mem_dst == src))
            return FWD_MEM;
        else if (wb_wb && (wb_dst != 4'd0) && (wb_dst == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign mem_stall = MEM_Req & ~MEM_Ready;

    assign load_use = EX_MemRead & EX_WBEnable & (EX_DstReg != 4'd0) &
                      ((EX_DstReg == ID_Src1) |
                       (ID_Src2Valid & (EX_DstReg == ID_Src2)));

    // State, wait counter and sticky timeout flag registers.
    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state: memory stalls accumulate toward the watchdog limit; ERROR is terminal.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (state_q != ST_ERR) begin
            if (mem_stall) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (wait_cnt_d == TIMEOUT_LIM) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end else begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        end
    end

    // Pipeline controls in priority order: reset, ERROR, memory stall, branch, load-use.
    always_comb begin
        PC_Freeze    = 1'b0;
        IFID_Freeze  = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Freeze  = 1'b0;
        IDEX_Flush   = 1'b0;
        EXMEM_Freeze = 1'b0;
        Fwd_Sel1     = FWD_RF;
        Fwd_Sel2     = FWD_RF;
        if (rst) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else begin
            Fwd_Sel1 = fwd_sel(EX_Src1, MEM_DstReg, MEM_WBEnable, WB_DstReg, WB_WBEnable);
            Fwd_Sel2 = fwd_sel(EX_Src2, MEM_DstReg, MEM_WBEnable, WB_DstReg, WB_WBEnable);
            if (state_q == ST_ERR || mem_stall) begin
                PC_Freeze    = 1'b1;
                IFID_Freeze  = 1'b1;
                IDEX_Freeze  = 1'b1;
                EXMEM_Freeze = 1'b1;
            end else if (EX_BrTaken) begin
                IFID_Flush = 1'b1;
                IDEX_Flush = 1'b1;
            end else if (load_use) begin
                PC_Freeze   = 1'b1;
                IFID_Freeze = 1'b1;
                IDEX_Flush  = 1'b1;
            end
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge Clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (PC_Freeze && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign State      = state_q;
    assign MemTimeout = timeout_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       rst;
    logic [3:0] ID_Src1, ID_Src2, EX_Src1, EX_Src2, EX_DstReg, MEM_DstReg, WB_DstReg;
    logic       ID_Src2Valid, EX_WBEnable, EX_MemRead, EX_BrTaken;
    logic       MEM_WBEnable, MEM_Req, MEM_Ready, WB_WBEnable;
    logic       PC_Freeze, IFID_Freeze, IFID_Flush, IDEX_Freeze, IDEX_Flush, EXMEM_Freeze;
    logic [1:0] Fwd_Sel1, Fwd_Sel2, State;
    logic       MemTimeout;
    logic [3:0] StallCount;
    logic [5:0] ctl;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // ctl = {PC_Freeze, IFID_Freeze, IFID_Flush, IDEX_Freeze, IDEX_Flush, EXMEM_Freeze}
    localparam logic [5:0] CTL_NONE  = 6'b000000;
    localparam logic [5:0] CTL_FLUSH = 6'b001010;
    localparam logic [5:0] CTL_ALLFZ = 6'b110101;
    localparam logic [5:0] CTL_LU    = 6'b110010;

    assign ctl = {PC_Freeze, IFID_Freeze, IFID_Flush, IDEX_Freeze, IDEX_Flush, EXMEM_Freeze};

    always #5 Clk = ~Clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .Clk(Clk), .rst(rst),
        .ID_Src1(ID_Src1), .ID_Src2(ID_Src2), .ID_Src2Valid(ID_Src2Valid),
        .EX_Src1(EX_Src1), .EX_Src2(EX_Src2), .EX_DstReg(EX_DstReg),
        .EX_WBEnable(EX_WBEnable), .EX_MemRead(EX_MemRead), .EX_BrTaken(EX_BrTaken),
        .MEM_DstReg(MEM_DstReg), .MEM_WBEnable(MEM_WBEnable),
        .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
        .WB_DstReg(WB_DstReg), .WB_WBEnable(WB_WBEnable),
        .PC_Freeze(PC_Freeze), .IFID_Freeze(IFID_Freeze), .IFID_Flush(IFID_Flush),
        .IDEX_Freeze(IDEX_Freeze), .IDEX_Flush(IDEX_Flush), .EXMEM_Freeze(EXMEM_Freeze),
        .Fwd_Sel1(Fwd_Sel1), .Fwd_Sel2(Fwd_Sel2), .State(State),
        .MemTimeout(MemTimeout), .StallCount(StallCount)
    );

    task automatic idle();
        ID_Src1 = 4'd0; ID_Src2 = 4'd0; ID_Src2Valid = 1'b0;
        EX_Src1 = 4'd0; EX_Src2 = 4'd0; EX_DstReg = 4'd0;
        EX_WBEnable = 1'b0; EX_MemRead = 1'b0; EX_BrTaken = 1'b0;
        MEM_DstReg = 4'd0; MEM_WBEnable = 1'b0; MEM_Req = 1'b0; MEM_Ready = 1'b0;
        WB_DstReg = 4'd0; WB_WBEnable = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        MEM_Req = 1'b1; MEM_Ready = 1'b0; EX_BrTaken = 1'b1;
        EX_Src1 = 4'd5; EX_Src2 = 4'd5; MEM_DstReg = 4'd5; MEM_WBEnable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total_cnt++;
            if (ctl !== CTL_FLUSH) $display("FAIL reset_ctl cyc%0d got %b want %b", i, ctl, CTL_FLUSH);
            else pass_cnt++;
            total_cnt++;
            if ({Fwd_Sel1, Fwd_Sel2} !== 4'b0000) $display("FAIL reset_fwd got %b want 0000", {Fwd_Sel1, Fwd_Sel2});
            else pass_cnt++;
            @(posedge Clk);
        end
        #1;
        rst = 1'b0;
        idle();
        #1;
        total_cnt++;
        if (State !== 2'b00) $display("FAIL reset_state got %b want 00", State);
        else pass_cnt++;
        total_cnt++;
        if (StallCount !== 4'd0) $display("FAIL reset_stallcnt got %0d want 0", StallCount);
        else pass_cnt++;
        total_cnt++;
        if (MemTimeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", MemTimeout);
        else pass_cnt++;
        total_cnt++;
        if (ctl !== CTL_NONE) $display("FAIL idle_ctl got %b want %b", ctl, CTL_NONE);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        EX_MemRead = 1'b1; EX_WBEnable = 1'b1; EX_DstReg = 4'd3; ID_Src1 = 4'd3;
        #1;
        total_cnt++;
        if (ctl !== CTL_LU) $display("FAIL lu_src1 got %b want %b", ctl, CTL_LU);
        else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (StallCount !== 4'd1) $display("FAIL lu_stallcnt got %0d want 1", StallCount);
        else pass_cnt++;
        total_cnt++;
        if (ctl !== CTL_NONE) $display("FAIL lu_released got %b want %b", ctl, CTL_NONE);
        else pass_cnt++;
        // load to r0 is never a hazard
        EX_MemRead = 1'b1; EX_WBEnable = 1'b1; EX_DstReg = 4'd0; ID_Src1 = 4'd0;
        #1;
        total_cnt++;
        if (ctl !== CTL_NONE) $display("FAIL lu_r0 got %b want %b", ctl, CTL_NONE);
        else pass_cnt++;
        step();
        total_cnt++;
        if (StallCount !== 4'd1) $display("FAIL lu_r0_cnt got %0d want 1", StallCount);
        else pass_cnt++;
        // Src2 match only counts when Src2 is actually read
        EX_DstReg = 4'd3; ID_Src1 = 4'd7; ID_Src2 = 4'd3; ID_Src2Valid = 1'b0;
        #1;
        total_cnt++;
        if (ctl !== CTL_NONE) $display("FAIL lu_src2_invalid got %b want %b", ctl, CTL_NONE);
        else pass_cnt++;
        ID_Src2Valid = 1'b1;
        #1;
        total_cnt++;
        if (ctl !== CTL_LU) $display("FAIL lu_src2 got %b want %b", ctl, CTL_LU);
        else pass_cnt++;
        // non-load producer does not stall
        EX_MemRead = 1'b0;
        #1;
        total_cnt++;
        if (ctl !== CTL_NONE) $display("FAIL lu_not_load got %b want %b", ctl, CTL_NONE);
        else pass_cnt++;
        // branch outranks load-use
        EX_MemRead = 1'b1; EX_BrTaken = 1'b1;
        #1;
        total_cnt++;
        if (ctl !== CTL_FLUSH) $display("FAIL br_over_lu got %b want %b", ctl, CTL_FLUSH);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_forwarding();
        do_reset();
        EX_Src1 = 4'd5; EX_Src2 = 4'd5;
        MEM_DstReg = 4'd5; MEM_WBEnable = 1'b1; WB_DstReg = 4'd5; WB_WBEnable = 1'b1;
        #1;
        total_cnt++;
        if ({Fwd_Sel1, Fwd_Sel2} !== 4'b0101) $display("FAIL fwd_mem got %b want 0101", {Fwd_Sel1, Fwd_Sel2});
        else pass_cnt++;
        MEM_WBEnable = 1'b0;
        #1;
        total_cnt++;
        if ({Fwd_Sel1, Fwd_Sel2} !== 4'b1010) $display("FAIL fwd_wb got %b want 1010", {Fwd_Sel1, Fwd_Sel2});
        else pass_cnt++;
        EX_Src1 = 4'd0; EX_Src2 = 4'd0; MEM_DstReg = 4'd0; MEM_WBEnable = 1'b1; WB_DstReg = 4'd0;
        #1;
        total_cnt++;
        if ({Fwd_Sel1, Fwd_Sel2} !== 4'b0000) $display("FAIL fwd_r0 got %b want 0000", {Fwd_Sel1, Fwd_Sel2});
        else pass_cnt++;
        EX_Src1 = 4'd5; EX_Src2 = 4'd6; MEM_DstReg = 4'd5; WB_DstReg = 4'd6;
        #1;
        total_cnt++;
        if ({Fwd_Sel1, Fwd_Sel2} !== 4'b0110) $display("FAIL fwd_indep got %b want 0110", {Fwd_Sel1, Fwd_Sel2});
        else pass_cnt++;
        EX_Src1 = 4'd9; EX_Src2 = 4'd5;
        #1;
        total_cnt++;
        if ({Fwd_Sel1, Fwd_Sel2} !== 4'b0001) $display("FAIL fwd_op2_mem got %b want 0001", {Fwd_Sel1, Fwd_Sel2});
        else pass_cnt++;
        EX_Src1 = 4'd5; EX_Src2 = 4'd6; MEM_Req = 1'b1; MEM_Ready = 1'b0;
        #1;
        total_cnt++;
        if ({Fwd_Sel1, Fwd_Sel2} !== 4'b0110) $display("FAIL fwd_in_freeze got %b want 0110", {Fwd_Sel1, Fwd_Sel2});
        else pass_cnt++;
        idle();
    endtask

    task automatic test_mem_wait_branch();
        do_reset();
        MEM_Req = 1'b1; MEM_Ready = 1'b0; EX_BrTaken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (ctl !== CTL_ALLFZ) $display("FAIL memwait_ctl cyc%0d got %b want %b", i, ctl, CTL_ALLFZ);
            else pass_cnt++;
            step();
            total_cnt++;
            if (State !== 2'b01) $display("FAIL memwait_state cyc%0d got %b want 01", i, State);
            else pass_cnt++;
        end
        MEM_Ready = 1'b1;
        #1;
        total_cnt++;
        if (ctl !== CTL_FLUSH) $display("FAIL ready_branch got %b want %b", ctl, CTL_FLUSH);
        else pass_cnt++;
        step();
        total_cnt++;
        if (State !== 2'b00) $display("FAIL ready_state got %b want 00", State);
        else pass_cnt++;
        total_cnt++;
        if (StallCount !== 4'd3) $display("FAIL memwait_cnt got %0d want 3", StallCount);
        else pass_cnt++;
        total_cnt++;
        if (MemTimeout !== 1'b0) $display("FAIL memwait_timeout got %b want 0", MemTimeout);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_timeout();
        do_reset();
        MEM_Req = 1'b1; MEM_Ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            total_cnt++;
            if (State !== ((i < 4) ? 2'b01 : 2'b10)) $display("FAIL to_state cyc%0d got %b want %b", i, State, (i < 4) ? 2'b01 : 2'b10);
            else pass_cnt++;
            total_cnt++;
            if (MemTimeout !== (i == 4)) $display("FAIL to_flag cyc%0d got %b want %b", i, MemTimeout, (i == 4));
            else pass_cnt++;
        end
        MEM_Ready = 1'b1; MEM_Req = 1'b0; EX_BrTaken = 1'b1;
        #1;
        total_cnt++;
        if (ctl !== CTL_ALLFZ) $display("FAIL err_ctl got %b want %b", ctl, CTL_ALLFZ);
        else pass_cnt++;
        step();
        total_cnt++;
        if (State !== 2'b10 || MemTimeout !== 1'b1) $display("FAIL err_sticky got %b/%b want 10/1", State, MemTimeout);
        else pass_cnt++;
        do_reset();
        #1;
        total_cnt++;
        if (State !== 2'b00 || MemTimeout !== 1'b0 || ctl !== CTL_NONE)
            $display("FAIL err_reset got %b/%b/%b want 00/0/000000", State, MemTimeout, ctl);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        EX_MemRead = 1'b1; EX_WBEnable = 1'b1; EX_DstReg = 4'd4; ID_Src1 = 4'd4;
        for (int i = 1; i <= 20; i++) begin
            step();
            total_cnt++;
            if (StallCount !== ((i < 15) ? 4'(i) : 4'd15))
                $display("FAIL sat_cnt cyc%0d got %0d want %0d", i, StallCount, (i < 15) ? i : 15);
            else pass_cnt++;
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_forwarding();
        test_mem_wait_branch();
        test_timeout();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage 16-bit pipeline. It drives the freeze and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers, and selects forwarding paths for the two EX-stage ALU operands. It resolves load-use hazards, taken branches and data-memory wait states. It also keeps a memory-timeout watchdog and a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before the ERROR state (range 2..255)
CNT_W, 16, width of the StallCount performance counter

Ports:
Clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
ID_Src1  in  4  source register 1 of the instruction in ID
ID_Src2  in  4  source register 2 of the instruction in ID
ID_Src2Valid  in  1  ID instruction reads Src2 (R-type or store)
EX_Src1  in  4  Src1Out of ID/EX
EX_Src2  in  4  Src2Out of ID/EX
EX_DstReg  in  4  DstRegOut of ID/EX
EX_WBEnable  in  1  WBEnable of ID/EX
EX_MemRead  in  1  MemReadOut of ID/EX
EX_BrTaken  in  1  branch resolved taken in EX
MEM_DstReg  in  4  destination register in EX/MEM
MEM_WBEnable  in  1  write-back enable in EX/MEM
MEM_Req  in  1  MEM stage is issuing a data-memory read or write
MEM_Ready  in  1  data memory completes the access this cycle
WB_DstReg  in  4  destination register in MEM/WB
WB_WBEnable  in  1  write-back enable in MEM/WB
PC_Freeze  out  1  hold PC
IFID_Freeze  out  1  hold IF/ID
IFID_Flush  out  1  load NOP into IF/ID
IDEX_Freeze  out  1  hold ID/EX
IDEX_Flush  out  1  load bubble (all controls 0) into ID/EX
EXMEM_Freeze  out  1  hold EX/MEM and MEM/WB
Fwd_Sel1  out  2  ALU operand 1 source: 00 reg file, 01 EX/MEM result, 10 WB value
Fwd_Sel2  out  2  same for operand 2 / store data
State  out  2  00 RUN, 01 MEM_WAIT, 10 ERROR
MemTimeout  out  1  sticky watchdog flag
StallCount  out  CNT_W  saturating count of cycles with PC_Freeze=1

Behaviour:
- Registered: State, wait counter (8 bit), MemTimeout, StallCount. All other outputs are combinational from state and inputs, so they act in the same cycle.
- While rst=1:
  - IFID_Flush=1 and IDEX_Flush=1.
  - All freezes are 0 and Fwd_Sel1/Fwd_Sel2 are 00.
  - On the next edge: State=RUN, wait counter=0, MemTimeout=0, StallCount=0.
- Register 0 is never a hazard source: any match against DstReg 0 is ignored.
- MemStall = MEM_Req & ~MEM_Ready.
- Priority: ERROR > MemStall > branch > load-use.
- ERROR state:
  - All four freezes are 1 and both flushes are 0.
  - The state is left only by rst.
- MemStall, in RUN or MEM_WAIT:
  - PC_Freeze, IFID_Freeze, IDEX_Freeze and EXMEM_Freeze are all 1.
  - Both flushes are 0, so a pending branch is held, not lost.
  - Next state is MEM_WAIT and the wait counter increments.
  - When the counter would reach MEM_TIMEOUT, the next state is ERROR and MemTimeout is set to 1.
- MEM_Ready=1 while in MEM_WAIT: no memory freeze this cycle, next state RUN, counter cleared. Branch and load-use rules apply in this same cycle.
- Branch (no MemStall, EX_BrTaken=1): IFID_Flush=1 and IDEX_Flush=1, no freezes. This gives a 2-cycle penalty.
- Load-use (no MemStall, no branch): EX_MemRead & EX_WBEnable & EX_DstReg≠0 & (EX_DstReg==ID_Src1 | (ID_Src2Valid & EX_DstReg==ID_Src2)).
  - Response: PC_Freeze=1, IFID_Freeze=1, IDEX_Flush=1, giving exactly one bubble.
  - The next cycle resolves through forwarding from WB.
- Forwarding, evaluated independently for each operand (shown for operand 1):
  - Fwd_Sel1=01 if MEM_WBEnable & MEM_DstReg≠0 & MEM_DstReg==EX_Src1.
  - Else Fwd_Sel1=10 if WB_WBEnable & WB_DstReg≠0 & WB_DstReg==EX_Src1.
  - Else 00. EX/MEM takes priority over WB.
  - Fwd_Sel2 uses the same rules with EX_Src2.
  - Forwarding outputs stay valid during freezes.
- StallCount increments on every edge where PC_Freeze=1 and saturates at all-ones.

Test Plan:
- Reset: hold rst 2 cycles with MEM_Req=1, MEM_Ready=0 -> both flushes 1, all freezes 0; after release State=00, StallCount=0, MemTimeout=0.
- Load-use: EX_MemRead=1, EX_WBEnable=1, EX_DstReg=3, ID_Src1=3 for 1 cycle -> PC_Freeze=IFID_Freeze=IDEX_Flush=1 for exactly 1 cycle, StallCount=1. Repeat with EX_DstReg=0 -> no stall.
- Forwarding: EX_Src1=5, EX_Src2=5, MEM_DstReg=5/WBEn=1, WB_DstReg=5/WBEn=1 -> Fwd_Sel1=Fwd_Sel2=01. Drop MEM_WBEnable -> both 10. Set all DstReg=0 -> both 00.
- Memory wait plus branch: MEM_Req=1, MEM_Ready=0 for 3 cycles with EX_BrTaken=1 -> 4 freezes high and flushes 0 for 3 cycles, State=01. Ready cycle -> freezes 0, IFID_Flush=IDEX_Flush=1, State returns 00, StallCount=3.
- Timeout: MEM_Req=1, MEM_Ready=0 held with MEM_TIMEOUT=4 -> State=10 and MemTimeout=1 after the 4th cycle. Freezes stay 1 even after MEM_Ready=1; only rst clears them.
- Saturation: CNT_W=4, 20 consecutive stall cycles -> StallCount holds 15.
